uart_echo_buf: RTL and testbench

- Sits between the UART receiver and the UART transmitter in the loopback/echo build of the top level.
- Captures every received byte into a power-of-two FIFO, then drains it to the transmitter one byte at a time using the transmitter's tx_en/tx_busy handshake.
- Optionally inserts a line feed after every carriage return so a terminal sees proper line breaks.
- Replaces the fixed message source when the top is built in echo mode.

---
 rtl/uart_echo_buf.sv | 170 +++++++++++++++++
 tb/tb_uart_echo_buf.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buf.sv
// rtl/uart_echo_buf.sv - receive-to-transmit echo buffer with optional CR->CRLF expansion
//
// Captures received bytes into a power-of-two FIFO and drains them one at a
// time into a UART transmitter using its tx_en / tx_busy handshake.
//
// Ports:
//   CLK       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   rx_data   in   received byte, qualified by rx_valid
//   rx_valid  in   one-cycle receive strobe
//   tx_busy   in   transmitter busy, high from the cycle after tx_en to end of stop bit
//   tx_data   out  byte presented to the transmitter, held between loads
//   tx_en     out  one-cycle transmit start strobe
//   count     out  FIFO occupancy, 0..DEPTH
//   overflow  out  sticky: a received byte was dropped because the FIFO was full
//   idle      out  FIFO empty, no LF owed, state IDLE, transmitter not busy
module uart_echo_buf #(
    parameter int DEPTH = 16,
    parameter bit CR_LF = 1'b1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     tx_busy,
    output logic [7:0]               tx_data,
    output logic                     tx_en,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACK  = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_SEND_LF   = 2'd3
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;

    state_e        state_q;
    state_e        state_d;
    logic          pend_lf_q;
    logic          pend_lf_d;
    logic [7:0]    tx_data_q;
    logic [7:0]    tx_data_d;
    logic          tx_en_q;
    logic          tx_en_d;

    logic          full;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // Fullness is judged on the registered count only, so a pop in the same
    // cycle never makes room for that cycle's incoming byte.
    assign full = (count_q == FULL_COUNT);
    assign push = rx_valid && !full;
    assign head = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (rx_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain state machine
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pend_lf_q <= 1'b0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_lf_q <= pend_lf_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_lf_d = pend_lf_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // An owed LF takes priority over the next queued byte so the
                // CR/LF pair is never split.
                if (pend_lf_q && !tx_busy) begin
                    state_d = S_SEND_LF;
                end else if ((count_q != '0) && !tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = head;
                    tx_en_d   = 1'b1;
                    pend_lf_d = CR_LF && (head == 8'h0D);
                    state_d   = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            S_SEND_LF: begin
                tx_data_d = 8'h0A;
                tx_en_d   = 1'b1;
                pend_lf_d = 1'b0;
                state_d   = S_WAIT_ACK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    // Holding idle low while an LF is owed keeps a trailing CR from reporting
    // idle before its LF has gone out.
    assign idle     = (count_q == '0) && (state_q == S_IDLE) && !tx_busy && !pend_lf_q;

endmodule

// File: tb/tb_uart_echo_buf.sv
// tb/tb_uart_echo_buf.sv - directed self-checking bench for uart_echo_buf
module tb_uart_echo_buf;

    localparam int DEPTH    = 16;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int BUSY_LEN = 4;

    logic          CLK = 1'b0;
    logic          reset;

    logic [7:0]    rx_data_a;
    logic          rx_valid_a;
    logic          tx_busy_a;
    logic [7:0]    tx_data_a;
    logic          tx_en_a;
    logic [CW-1:0] count_a;
    logic          overflow_a;
    logic          idle_a;
    logic          hold_a;
    int            bcnt_a;

    logic [7:0]    rx_data_b;
    logic          rx_valid_b;
    logic          tx_busy_b;
    logic [7:0]    tx_data_b;
    logic          tx_en_b;
    logic [CW-1:0] count_b;
    logic          overflow_b;
    logic          idle_b;
    int            bcnt_b;

    logic [7:0]    log_a[$];
    logic [7:0]    log_b[$];
    int            viol_a = 0;
    int            viol_b = 0;
    logic          prev_en_a;
    logic          prev_en_b;

    int            checks = 0;
    int            errors = 0;

    always #5 CLK = ~CLK;

    uart_echo_buf #(.DEPTH(DEPTH), .CR_LF(1'b1)) dut_a (
        .CLK      (CLK),
        .reset    (reset),
        .rx_data  (rx_data_a),
        .rx_valid (rx_valid_a),
        .tx_busy  (tx_busy_a),
        .tx_data  (tx_data_a),
        .tx_en    (tx_en_a),
        .count    (count_a),
        .overflow (overflow_a),
        .idle     (idle_a)
    );

    uart_echo_buf #(.DEPTH(DEPTH), .CR_LF(1'b0)) dut_b (
        .CLK      (CLK),
        .reset    (reset),
        .rx_data  (rx_data_b),
        .rx_valid (rx_valid_b),
        .tx_busy  (tx_busy_b),
        .tx_data  (tx_data_b),
        .tx_en    (tx_en_b),
        .count    (count_b),
        .overflow (overflow_b),
        .idle     (idle_b)
    );

    // Transmitter models: busy for BUSY_LEN cycles after each tx_en; hold_a
    // lets the bench keep transmitter A busy indefinitely.
    always @(posedge CLK) begin
        if (reset)            bcnt_a <= 0;
        else if (tx_en_a)     bcnt_a <= BUSY_LEN;
        else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
    end
    assign tx_busy_a = hold_a | (bcnt_a != 0);

    always @(posedge CLK) begin
        if (reset)            bcnt_b <= 0;
        else if (tx_en_b)     bcnt_b <= BUSY_LEN;
        else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
    end
    assign tx_busy_b = (bcnt_b != 0);

    // Byte loggers plus handshake-rule watchers.
    always @(posedge CLK) begin
        if (!reset && tx_en_a) begin
            log_a.push_back(tx_data_a);
            if (tx_busy_a || prev_en_a === 1'b1) viol_a <= viol_a + 1;
        end
        prev_en_a <= tx_en_a;
    end

    always @(posedge CLK) begin
        if (!reset && tx_en_b) begin
            log_b.push_back(tx_data_b);
            if (tx_busy_b || prev_en_b === 1'b1) viol_b <= viol_b + 1;
        end
        prev_en_b <= tx_en_b;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qa(input int i);
        if (i < log_a.size()) return log_a[i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] qb(input int i);
        if (i < log_b.size()) return log_b[i];
        return 8'hxx;
    endfunction

    task automatic push_a(input logic [7:0] d);
        rx_valid_a = 1'b1;
        rx_data_a  = d;
        tick();
        rx_valid_a = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(idle_a === 1'b1 && idle_b === 1'b1) && n < 400) begin
            tick();
            n++;
        end
        check(tag, {30'd0, idle_a, idle_b}, 32'd3);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        rx_data_a  = 8'h00;
        rx_valid_a = 1'b0;
        rx_data_b  = 8'h00;
        rx_valid_b = 1'b0;
        hold_a     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_tx_en",    tx_en_a,    0);
        check("rst_tx_data",  tx_data_a,  8'h00);
        check("rst_count",    count_a,    0);
        check("rst_overflow", overflow_a, 0);
        check("rst_idle",     idle_a,     1);
        reset = 1'b0;
        tick();

        // Single byte latency
        log_a.delete();
        push_a(8'h41);
        check("t1_count_n1",  count_a, 1);
        check("t1_tx_en_n1",  tx_en_a, 0);
        tick();
        check("t1_tx_en_n2",  tx_en_a, 1);
        check("t1_tx_data",   tx_data_a, 8'h41);
        check("t1_count_n2",  count_a, 0);
        tick();
        check("t1_tx_en_one", tx_en_a, 0);
        check("t1_busy",      tx_busy_a, 1);
        wait_idle("t1_idle");
        check("t1_nbytes",    log_a.size(), 1);
        check("t1_byte0",     qa(0), 8'h41);
        check("t1_overflow",  overflow_a, 0);

        // Burst while transmitter busy
        log_a.delete();
        hold_a = 1'b1;
        tick();
        push_a(8'h31);
        push_a(8'h32);
        push_a(8'h33);
        check("t2_count", count_a, 3);
        check("t2_no_en", tx_en_a, 0);
        hold_a = 1'b0;
        wait_idle("t2_idle");
        check("t2_nbytes", log_a.size(), 3);
        check("t2_byte0",  qa(0), 8'h31);
        check("t2_byte1",  qa(1), 8'h32);
        check("t2_byte2",  qa(2), 8'h33);

        // CR -> CR LF expansion on A, verbatim on B
        log_a.delete();
        log_b.delete();
        rx_valid_a = 1'b1; rx_data_a = 8'h0D;
        rx_valid_b = 1'b1; rx_data_b = 8'h0D;
        tick();
        rx_data_a = 8'h62;
        rx_data_b = 8'h62;
        tick();
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        wait_idle("t3_idle");
        check("t3_a_nbytes", log_a.size(), 3);
        check("t3_a_byte0",  qa(0), 8'h0D);
        check("t3_a_byte1",  qa(1), 8'h0A);
        check("t3_a_byte2",  qa(2), 8'h62);
        check("t3_b_nbytes", log_b.size(), 2);
        check("t3_b_byte0",  qb(0), 8'h0D);
        check("t3_b_byte1",  qb(1), 8'h62);

        // Overflow with transmitter held busy
        log_a.delete();
        hold_a = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) push_a(8'h40 + 8'(i));
        check("t4_count_full", count_a, DEPTH);
        check("t4_ovf_before", overflow_a, 0);
        push_a(8'h50);
        check("t4_ovf_17",     overflow_a, 1);
        check("t4_count_17",   count_a, DEPTH);
        push_a(8'h51);
        check("t4_count_18",   count_a, DEPTH);
        hold_a = 1'b0;
        wait_idle("t4_idle");
        check("t4_nbytes", log_a.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check($sformatf("t4_byte%0d", i), qa(i), 8'h40 + 8'(i));
        check("t4_ovf_sticky", overflow_a, 1);

        // Full FIFO: pop and push in the same cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        log_a.delete();
        hold_a = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) push_a(8'h20 + 8'(i));
        check("t5_count_full", count_a, DEPTH);
        check("t5_ovf_before", overflow_a, 0);
        hold_a     = 1'b0;
        rx_valid_a = 1'b1;
        rx_data_a  = 8'h99;
        tick();
        rx_valid_a = 1'b0;
        check("t5_count",    count_a, DEPTH - 1);
        check("t5_overflow", overflow_a, 1);
        check("t5_tx_en",    tx_en_a, 1);
        check("t5_tx_data",  tx_data_a, 8'h20);
        wait_idle("t5_idle");
        check("t5_nbytes",   log_a.size(), DEPTH);
        check("t5_last",     qa(DEPTH - 1), 8'h2F);

        // Reset while in WAIT_DONE with 5 bytes queued
        push_a(8'h70);
        n = 0;
        while (tx_busy_a !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t6_busy_seen", tx_busy_a, 1);
        hold_a = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) push_a(8'h70 + 8'(i));
        check("t6_count5", count_a, 5);
        reset  = 1'b1;
        hold_a = 1'b0;
        tick();
        reset = 1'b0;
        log_a.delete();
        check("t6_count",    count_a,    0);
        check("t6_tx_en",    tx_en_a,    0);
        check("t6_tx_data",  tx_data_a,  8'h00);
        check("t6_overflow", overflow_a, 0);
        check("t6_idle",     idle_a,     1);
        repeat (20) tick();
        check("t6_no_tx",    log_a.size(), 0);
        check("t6_idle_end", idle_a, 1);

        // Handshake rules across the whole run
        check("viol_a", viol_a, 0);
        check("viol_b", viol_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
